// File: rtl/usb_tx_scheduler.sv
// usb_tx_scheduler: arbitrates ACK/NAK/DATA requests for the bulk endpoint and
// issues one tx_packet command at a time to usb_tx, tracking completion and the
// host handshake before the TX buffer is released.
module usb_tx_scheduler #(
    parameter int HOLD_CYCLES  = 8,
    parameter int MAX_PKT      = 64,
    parameter int TX_TIMEOUT   = 2048,
    parameter int HACK_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       out_ok,
    input  logic       out_full,
    input  logic       in_token,
    input  logic [6:0] buf_occupancy,
    input  logic       tx_done,
    input  logic       host_ack,
    output logic [1:0] tx_packet,
    output logic [6:0] tx_packet_size,
    output logic       tx_busy,
    output logic       buf_clear,
    output logic       tx_error
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_TX, WAIT_HACK} state_t;

    localparam logic [1:0] PKT_IDLE = 2'b00;
    localparam logic [1:0] PKT_DATA = 2'b01;
    localparam logic [1:0] PKT_NAK  = 2'b10;
    localparam logic [1:0] PKT_ACK  = 2'b11;

    localparam int TMAX = (TX_TIMEOUT > HACK_TIMEOUT) ? TX_TIMEOUT : HACK_TIMEOUT;
    localparam int CW   = $clog2(TMAX) + 1;
    localparam int HW   = $clog2(HOLD_CYCLES) + 1;

    localparam logic [CW-1:0] TX_LIM   = CW'(TX_TIMEOUT - 1);
    localparam logic [CW-1:0] HACK_LIM = CW'(HACK_TIMEOUT - 1);
    localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_CYCLES - 1);
    localparam logic [6:0]    MAX_SZ   = 7'(MAX_PKT);

    state_t        state;
    logic          p_ack, p_nak, p_in;
    logic [1:0]    code;       // kind of the packet in flight
    logic [HW-1:0] hold_cnt;
    logic [CW-1:0] to_cnt;

    logic          any_pend;
    logic          clr_ack, clr_nak, clr_in;
    logic [1:0]    sel_code;
    logic [6:0]    size_c;
    logic [CW-1:0] to_inc;

    // Fixed-priority pick among pending requests; only acted on in IDLE.
    always_comb begin
        any_pend = p_ack | p_nak | p_in;
        clr_ack  = 1'b0;
        clr_nak  = 1'b0;
        clr_in   = 1'b0;
        sel_code = PKT_IDLE;
        size_c   = (buf_occupancy > MAX_SZ) ? MAX_SZ : buf_occupancy;
        to_inc   = (&to_cnt) ? to_cnt : to_cnt + 1'b1;
        if (p_ack) begin
            sel_code = PKT_ACK;
            clr_ack  = (state == IDLE);
        end else if (p_nak) begin
            sel_code = PKT_NAK;
            clr_nak  = (state == IDLE);
        end else if (p_in) begin
            // An IN with nothing buffered is answered with NAK.
            sel_code = (buf_occupancy == 7'd0) ? PKT_NAK : PKT_DATA;
            clr_in   = (state == IDLE);
        end
    end

    // Pending request flags; a new pulse wins over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_ack <= 1'b0;
            p_nak <= 1'b0;
            p_in  <= 1'b0;
        end else begin
            p_ack <= out_ok   | (p_ack & ~clr_ack);
            p_nak <= out_full | (p_nak & ~clr_nak);
            p_in  <= in_token | (p_in  & ~clr_in);
        end
    end

    // Packet sequencing FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            code           <= PKT_IDLE;
            hold_cnt       <= '0;
            to_cnt         <= '0;
            tx_packet      <= PKT_IDLE;
            tx_packet_size <= 7'd0;
            tx_busy        <= 1'b0;
            buf_clear      <= 1'b0;
            tx_error       <= 1'b0;
        end else begin
            buf_clear <= 1'b0;
            tx_error  <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_pend) begin
                        code      <= sel_code;
                        tx_packet <= sel_code;
                        if (sel_code == PKT_DATA) tx_packet_size <= size_c;
                        hold_cnt  <= '0;
                        to_cnt    <= '0;
                        tx_busy   <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // tx_done here is ignored; the timeout already runs.
                    to_cnt <= to_inc;
                    if (hold_cnt == HOLD_LIM) begin
                        tx_packet <= PKT_IDLE;
                        state     <= WAIT_TX;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                WAIT_TX: begin
                    if (tx_done) begin
                        if (code == PKT_DATA) begin
                            to_cnt <= '0;
                            state  <= WAIT_HACK;
                        end else begin
                            tx_busy <= 1'b0;
                            state   <= IDLE;
                        end
                    end else if (to_cnt == TX_LIM) begin
                        tx_error <= 1'b1;
                        tx_busy  <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        to_cnt <= to_inc;
                    end
                end
                WAIT_HACK: begin
                    if (host_ack) begin
                        buf_clear <= 1'b1;
                        tx_busy   <= 1'b0;
                        state     <= IDLE;
                    end else if (to_cnt == HACK_LIM) begin
                        // Buffer is kept so the host's retried IN resends it.
                        tx_error <= 1'b1;
                        tx_busy  <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        to_cnt <= to_inc;
                    end
                end
                default: begin
                    tx_packet <= PKT_IDLE;
                    tx_busy   <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Directed testbench for usb_tx_scheduler. Inputs change and outputs are
// sampled on the falling edge, away from the active rising edge.
module tb_usb_tx_scheduler;

    logic       tb_clk = 1'b0;
    logic       rst = 1'b1;
    logic       out_ok = 1'b0, out_full = 1'b0, in_token = 1'b0;
    logic [6:0] buf_occupancy = 7'd0;
    logic       tx_done = 1'b0, host_ack = 1'b0;
    logic [1:0] tx_packet;
    logic [6:0] tx_packet_size;
    logic       tx_busy, buf_clear, tx_error;

    int checks = 0;
    int failures = 0;

    usb_tx_scheduler dut (
        .clk(tb_clk), .rst(rst), .out_ok(out_ok), .out_full(out_full),
        .in_token(in_token), .buf_occupancy(buf_occupancy), .tx_done(tx_done),
        .host_ack(host_ack), .tx_packet(tx_packet), .tx_packet_size(tx_packet_size),
        .tx_busy(tx_busy), .buf_clear(buf_clear), .tx_error(tx_error)
    );

    always #5 tb_clk = ~tb_clk;

    // Sticky monitor of buf_clear for scenarios that must never flush.
    logic clear_seen = 1'b0;
    always @(posedge tb_clk) if (buf_clear) clear_seen <= 1'b1;

    task automatic tick();
        @(negedge tb_clk);
    endtask

    // Count consecutive samples where tx_packet shows code (bounded).
    task automatic measure_hold(input logic [1:0] c, output int n);
        n = 0;
        while (tx_packet === c && n < 40) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        tick();
        checks++;
        if ({tx_packet, tx_packet_size, tx_busy, buf_clear, tx_error} !== 12'd0) begin
            failures++;
            $display("FAIL reset_outputs got pkt=%b size=%0d busy=%b clr=%b err=%b want all 0",
                     tx_packet, tx_packet_size, tx_busy, buf_clear, tx_error);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_ack();
        int n;
        clear_seen = 1'b0;
        out_ok = 1'b1; tick(); out_ok = 1'b0;
        checks++;
        if (tx_packet !== 2'b00) begin
            failures++; $display("FAIL ack_not_early got %b want 00", tx_packet);
        end
        tick();
        checks++;
        if (tx_packet !== 2'b11 || tx_busy !== 1'b1) begin
            failures++; $display("FAIL ack_issue got pkt=%b busy=%b want 11/1", tx_packet, tx_busy);
        end
        measure_hold(2'b11, n);
        checks++;
        if (n != 8) begin failures++; $display("FAIL ack_hold got %0d want 8", n); end
        // host_ack outside WAIT_HACK must do nothing.
        host_ack = 1'b1; tick(); host_ack = 1'b0;
        checks++;
        if (tx_busy !== 1'b1 || tx_packet !== 2'b00) begin
            failures++; $display("FAIL ack_wait_tx got pkt=%b busy=%b want 00/1", tx_packet, tx_busy);
        end
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        tick();
        checks++;
        if (tx_busy !== 1'b0 || clear_seen !== 1'b0) begin
            failures++; $display("FAIL ack_done got busy=%b clr_seen=%b want 0/0", tx_busy, clear_seen);
        end
    endtask

    task automatic test_data();
        int n;
        buf_occupancy = 7'd2;
        in_token = 1'b1; tick(); in_token = 1'b0;
        tick();
        checks++;
        if (tx_packet !== 2'b01 || tx_packet_size !== 7'd2) begin
            failures++; $display("FAIL data_issue got pkt=%b size=%0d want 01/2", tx_packet, tx_packet_size);
        end
        // tx_done during the hold must be ignored.
        n = 0;
        while (tx_packet === 2'b01 && n < 40) begin
            tx_done = (n == 2);
            n++;
            tick();
        end
        tx_done = 1'b0;
        checks++;
        if (n != 8 || tx_busy !== 1'b1) begin
            failures++; $display("FAIL data_hold got n=%0d busy=%b want 8/1", n, tx_busy);
        end
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        tick(); tick();
        checks++;
        if (tx_busy !== 1'b1 || buf_clear !== 1'b0) begin
            failures++; $display("FAIL data_wait_hack got busy=%b clr=%b want 1/0", tx_busy, buf_clear);
        end
        host_ack = 1'b1; tick(); host_ack = 1'b0;
        checks++;
        if (buf_clear !== 1'b1 || tx_busy !== 1'b0) begin
            failures++; $display("FAIL data_clear got clr=%b busy=%b want 1/0", buf_clear, tx_busy);
        end
        tick();
        checks++;
        if (buf_clear !== 1'b0 || tx_packet !== 2'b00) begin
            failures++; $display("FAIL data_clear_len got clr=%b pkt=%b want 0/00", buf_clear, tx_packet);
        end
    endtask

    task automatic test_nak();
        int n;
        logic seen;
        buf_occupancy = 7'd0;
        in_token = 1'b1; tick(); in_token = 1'b0;
        tick();
        checks++;
        if (tx_packet !== 2'b10 || tx_packet_size !== 7'd2) begin
            failures++; $display("FAIL nak_issue got pkt=%b size=%0d want 10/2", tx_packet, tx_packet_size);
        end
        measure_hold(2'b10, n);
        checks++;
        if (n != 8) begin failures++; $display("FAIL nak_hold got %0d want 8", n); end
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (tx_packet !== 2'b00 || tx_busy !== 1'b0) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL nak_single got extra=%b want 0", seen); end
    endtask

    task automatic test_back_to_back();
        int n;
        buf_occupancy = 7'd5;
        out_ok = 1'b1; in_token = 1'b1; tick(); out_ok = 1'b0; in_token = 1'b0;
        tick();
        checks++;
        if (tx_packet !== 2'b11) begin failures++; $display("FAIL b2b_first got %b want 11", tx_packet); end
        measure_hold(2'b11, n);
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        checks++;
        if (tx_busy !== 1'b0) begin failures++; $display("FAIL b2b_gap got busy=%b want 0", tx_busy); end
        tick();
        checks++;
        if (tx_packet !== 2'b01 || tx_packet_size !== 7'd5) begin
            failures++; $display("FAIL b2b_second got pkt=%b size=%0d want 01/5", tx_packet, tx_packet_size);
        end
        measure_hold(2'b01, n);
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        host_ack = 1'b1; tick(); host_ack = 1'b0;
        checks++;
        if (buf_clear !== 1'b1) begin failures++; $display("FAIL b2b_clear got %b want 1", buf_clear); end
        tick();
    endtask

    task automatic test_hack_timeout();
        int n;
        clear_seen = 1'b0;
        buf_occupancy = 7'd70;
        in_token = 1'b1; tick(); in_token = 1'b0;
        tick();
        checks++;
        if (tx_packet !== 2'b01 || tx_packet_size !== 7'd64) begin
            failures++; $display("FAIL clamp_size got pkt=%b size=%0d want 01/64", tx_packet, tx_packet_size);
        end
        measure_hold(2'b01, n);
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        n = 0;
        do begin tick(); n++; end while (tx_error !== 1'b1 && n < 1200);
        checks++;
        if (n != 1024 || tx_busy !== 1'b0) begin
            failures++; $display("FAIL hack_timeout got n=%0d busy=%b want 1024/0", n, tx_busy);
        end
        tick();
        checks++;
        if (tx_error !== 1'b0 || clear_seen !== 1'b0) begin
            failures++; $display("FAIL hack_err_pulse got err=%b clr_seen=%b want 0/0", tx_error, clear_seen);
        end
        in_token = 1'b1; tick(); in_token = 1'b0;
        tick();
        checks++;
        if (tx_packet !== 2'b01 || tx_packet_size !== 7'd64) begin
            failures++; $display("FAIL hack_resend got pkt=%b size=%0d want 01/64", tx_packet, tx_packet_size);
        end
        measure_hold(2'b01, n);
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        host_ack = 1'b1; tick(); host_ack = 1'b0;
        tick();
    endtask

    task automatic test_tx_timeout();
        int n;
        buf_occupancy = 7'd0;
        in_token = 1'b1; tick(); in_token = 1'b0;
        tick();
        checks++;
        if (tx_packet !== 2'b10) begin failures++; $display("FAIL txto_issue got %b want 10", tx_packet); end
        n = 0;
        do begin tick(); n++; end while (tx_error !== 1'b1 && n < 2200);
        checks++;
        if (n != 2048 || tx_busy !== 1'b0 || tx_packet !== 2'b00) begin
            failures++; $display("FAIL tx_timeout got n=%0d busy=%b pkt=%b want 2048/0/00", n, tx_busy, tx_packet);
        end
        tick();
    endtask

    task automatic test_rst_abort();
        int n;
        buf_occupancy = 7'd3;
        in_token = 1'b1; tick(); in_token = 1'b0;
        tick();
        measure_hold(2'b01, n);
        tick();
        checks++;
        if (tx_busy !== 1'b1 || tx_packet_size !== 7'd3) begin
            failures++; $display("FAIL abort_pre got busy=%b size=%0d want 1/3", tx_busy, tx_packet_size);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({tx_packet, tx_packet_size, tx_busy, buf_clear, tx_error} !== 12'd0) begin
            failures++;
            $display("FAIL abort_async got pkt=%b size=%0d busy=%b clr=%b err=%b want all 0",
                     tx_packet, tx_packet_size, tx_busy, buf_clear, tx_error);
        end
        tick(); rst = 1'b0;
        tick(); tick();
        checks++;
        if (tx_packet !== 2'b00 || tx_busy !== 1'b0 || buf_clear !== 1'b0) begin
            failures++; $display("FAIL abort_after got pkt=%b busy=%b clr=%b want 00/0/0", tx_packet, tx_busy, buf_clear);
        end
    endtask

    initial begin
        test_reset();
        test_ack();
        test_data();
        test_nak();
        test_back_to_back();
        test_hack_timeout();
        test_tx_timeout();
        test_rst_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
